// File: rtl/loop_ctrl_seq.sv
// rtl/loop_ctrl_seq.sv - loop command sequencer issuing strobes to loop-index counters
module loop_ctrl_seq #(
   parameter int NUM_CNT = 3,
   parameter int CW      = 4
) (
   input  logic               Clk,
   input  logic               RST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [1:0]         cmd_sel,
   input  logic [CW-1:0]      cmd_imm,
   output logic [NUM_CNT-1:0] cnt_wen,
   output logic [NUM_CNT-1:0] cnt_clr,
   output logic [NUM_CNT-1:0] cnt_inc,
   output logic [CW-1:0]      cnt_bus,
   input  logic [NUM_CNT-1:0] cnt_z,
   output logic               done,
   output logic               taken,
   output logic               err
);

   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_TEST = 3'd3;
   localparam logic [2:0] OP_INCT = 3'd4;
   localparam logic [2:0] SEL_LIM = 3'(NUM_CNT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [2:0]           r_op;
   logic [1:0]           r_sel;
   logic                 r_ready, r_done, r_taken, r_err;
   logic [NUM_CNT-1:0]   r_wen, r_clr, r_inc;
   logic [CW-1:0]        r_bus;
   logic                 w_ready, w_done, w_taken, w_err;
   logic [NUM_CNT-1:0]   w_wen, w_clr, w_inc;
   logic [CW-1:0]        w_bus;
   logic                 w_accept, w_in_legal, w_lat_legal, w_z_sel;
   logic [NUM_CNT-1:0]   w_in_hot, w_lat_hot;

   function automatic logic f_legal(input logic [2:0] op, input logic [1:0] sel);
      return (op <= OP_INCT) && ({1'b0, sel} < SEL_LIM);
   endfunction

   function automatic logic [NUM_CNT-1:0] f_hot(input logic [1:0] sel);
      logic [NUM_CNT-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (sel == i[1:0]) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign w_accept    = cmd_valid && r_ready;
   assign w_in_legal  = f_legal(cmd_op, cmd_sel);
   assign w_in_hot    = f_hot(cmd_sel);
   assign w_lat_legal = f_legal(r_op, r_sel);
   assign w_lat_hot   = f_hot(r_sel);
   // Out-of-range selects give an all-zero mask, so no flag can leak through.
   assign w_z_sel     = |(cnt_z & w_lat_hot);

   assign cmd_ready = r_ready;
   assign cnt_wen   = r_wen;
   assign cnt_clr   = r_clr;
   assign cnt_inc   = r_inc;
   assign cnt_bus   = r_bus;
   assign done      = r_done;
   assign taken     = r_taken;
   assign err       = r_err;

   // State register, registered outputs and command latch.
   always_ff @(posedge Clk) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_sel   <= '0;
         r_ready <= 1'b1;
         r_wen   <= '0;
         r_clr   <= '0;
         r_inc   <= '0;
         r_bus   <= '0;
         r_done  <= 1'b0;
         r_taken <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= w_ready;
         r_wen   <= w_wen;
         r_clr   <= w_clr;
         r_inc   <= w_inc;
         r_bus   <= w_bus;
         r_done  <= w_done;
         r_taken <= w_taken;
         r_err   <= w_err;
         if (w_accept) begin
            r_op  <= cmd_op;
            r_sel <= cmd_sel;
         end
      end
   end

   // Next state plus the output values for the state being entered; strobes are
   // decoded from the live command at accept so they land in the ISSUE cycle.
   always_comb begin
      w_next  = r_state;
      w_wen   = '0;
      w_clr   = '0;
      w_inc   = '0;
      w_bus   = r_bus;
      w_done  = 1'b0;
      w_taken = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_ISSUE;
               if (w_in_legal) begin
                  case (cmd_op)
                     OP_CLR:  w_clr = w_in_hot;
                     OP_LOAD: begin
                        w_wen = w_in_hot;
                        w_bus = cmd_imm;
                     end
                     OP_INC, OP_INCT: w_inc = w_in_hot;
                     default: ;
                  endcase
               end
            end
         end
         S_ISSUE:  w_next = S_SETTLE;
         S_SETTLE: begin
            w_next = S_RESP;
            w_done = 1'b1;
            if (!w_lat_legal)
               w_err = 1'b1;
            else if (r_op == OP_TEST || r_op == OP_INCT)
               w_taken = w_z_sel;
         end
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      w_ready = (w_next == S_IDLE);
   end

endmodule
